// File: rtl/demux12_router.sv
// Registered 1:2 demultiplexer with a one-entry output buffer per channel and valid/ready handshakes.
// Optional per-channel delivered-word counters are enabled by defining DEMUX_CNT_EN.
module demux12_router #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             d1_valid,
  input  logic             d1_ready,
  output logic [WIDTH-1:0] d1_data,
  output logic             d2_valid,
  input  logic             d2_ready,
  output logic [WIDTH-1:0] d2_data
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] d1_count,
  output logic [CNT_W-1:0] d2_count
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ch_state_t;

  // Index 0 is channel D1, index 1 is channel D2.
  logic [1:0]       valid_vec;
  logic [1:0]       ready_vec;
  logic [1:0]       load_vec;
  logic [1:0]       drain_vec;
  logic [WIDTH-1:0] data_arr [2];

  assign ready_vec = {d2_ready, d1_ready};

  // A channel can take a word when it is empty or being drained this same cycle.
  always_comb begin
    in_ready = 1'b0;
    if (in_sel) begin
      in_ready = !valid_vec[1] || ready_vec[1];
    end else begin
      in_ready = !valid_vec[0] || ready_vec[0];
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      localparam logic CH_SEL = 1'(gi);

      ch_state_t        state_reg;
      ch_state_t        state_next;
      logic             valid;
      logic [WIDTH-1:0] data_reg;

      assign load_vec[gi]  = in_valid && in_ready && (in_sel == CH_SEL);
      assign drain_vec[gi] = valid && ready_vec[gi];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          state_reg <= EMPTY;
        end else begin
          state_reg <= state_next;
        end
      end

      // A load wins over a drain so simultaneous drain+load keeps the slot full.
      always_comb begin
        state_next = state_reg;
        if (load_vec[gi]) begin
          state_next = FULL;
        end else if (drain_vec[gi]) begin
          state_next = EMPTY;
        end
      end

      always_comb begin
        valid = (state_reg == FULL);
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          data_reg <= '0;
        end else if (load_vec[gi]) begin
          data_reg <= in_data;
        end
      end

      assign valid_vec[gi] = valid;
      assign data_arr[gi]  = data_reg;

`ifdef DEMUX_CNT_EN
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_reg <= '0;
        end else if (drain_vec[gi]) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      if (gi == 0) begin : g_cnt1
        assign d1_count = cnt_reg;
      end else begin : g_cnt2
        assign d2_count = cnt_reg;
      end
`endif
    end
  endgenerate

  assign d1_valid = valid_vec[0];
  assign d1_data  = data_arr[0];
  assign d2_valid = valid_vec[1];
  assign d2_data  = data_arr[1];

endmodule

// File: tb/tb_demux12_router.sv
// Self-checking bench for demux12_router: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a one-slot-per-channel model.
module tb_demux12_router;

  localparam int WIDTH  = 32;
  localparam int CNT_W  = 4;
  localparam int N_RAND = 3000;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_sel = 1'b0;
  logic             d1_valid;
  logic             d1_ready = 1'b0;
  logic [WIDTH-1:0] d1_data;
  logic             d2_valid;
  logic             d2_ready = 1'b0;
  logic [WIDTH-1:0] d2_data;
  logic [CNT_W-1:0] d1_count;
  logic [CNT_W-1:0] d2_count;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: each channel is a slot that is either empty or holds one word.
  bit               m_full [2];
  logic [WIDTH-1:0] m_word [2];
  int unsigned      m_drains [2];
  bit               exp_ready;

  demux12_router #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .d1_valid (d1_valid),
    .d1_ready (d1_ready),
    .d1_data  (d1_data),
    .d2_valid (d2_valid),
    .d2_ready (d2_ready),
    .d2_data  (d2_data)
`ifdef DEMUX_CNT_EN
    ,
    .d1_count (d1_count),
    .d2_count (d2_count)
`endif
  );

`ifndef DEMUX_CNT_EN
  assign d1_count = '0;
  assign d2_count = '0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_full[c]   = 1'b0;
      m_word[c]   = '0;
      m_drains[c] = 0;
    end
  endtask

  task automatic compare_outputs();
    check("d1_valid", {31'd0, d1_valid}, {31'd0, m_full[0]});
    check("d1_data",  d1_data, m_word[0]);
    check("d2_valid", {31'd0, d2_valid}, {31'd0, m_full[1]});
    check("d2_data",  d2_data, m_word[1]);
`ifdef DEMUX_CNT_EN
    check("d1_count", 32'(d1_count), 32'(m_drains[0] % (1 << CNT_W)));
    check("d2_count", 32'(d2_count), 32'(m_drains[1] % (1 << CNT_W)));
`endif
  endtask

  // Called at a negedge with inputs already driven; returns at the following negedge.
  task automatic cycle();
    bit rdy [2];
    bit acc;
    int s;
    rdy[0] = d1_ready;
    rdy[1] = d2_ready;
    s = in_sel ? 1 : 0;
    #1;
    exp_ready = !m_full[s] || rdy[s];
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    acc = in_valid && exp_ready;
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      if (m_full[c] && rdy[c]) begin
        m_full[c] = 1'b0;
        m_drains[c]++;
      end
    end
    if (acc) begin
      m_full[s] = 1'b1;
      m_word[s] = in_data;
    end
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic set_in(input bit v, input bit sel, input logic [WIDTH-1:0] d);
    in_valid = v;
    in_sel   = sel;
    in_data  = d;
  endtask

  initial begin
    bit hold;
    model_reset();

    // Reset held with a word offered.
    set_in(1'b1, 1'b0, 32'hCAFE0001);
    repeat (3) @(negedge clk);
    check("rst_d1_valid", {31'd0, d1_valid}, 32'd0);
    check("rst_d2_valid", {31'd0, d2_valid}, 32'd0);
    check("rst_d1_data",  d1_data, 32'd0);
    check("rst_d2_data",  d2_data, 32'd0);
    check("rst_d1_count", 32'(d1_count), 32'd0);
    reset_n = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // Route to D1 then D2.
    set_in(1'b1, 1'b0, 32'hDEADBEEF);
    cycle();
    check("route_d1_valid", {31'd0, d1_valid}, 32'd1);
    check("route_d1_data",  d1_data, 32'hDEADBEEF);
    check("route_d2_valid", {31'd0, d2_valid}, 32'd0);
    set_in(1'b1, 1'b1, 32'h12345678);
    cycle();
    check("route_d2_data", d2_data, 32'h12345678);
    check("route_d1_hold", d1_data, 32'hDEADBEEF);

    // Backpressure on D1 for 10 cycles, then same-cycle reload.
    set_in(1'b1, 1'b0, 32'h11111111);
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_d1_data",  d1_data, 32'hDEADBEEF);
    end
    d1_ready = 1'b1;
    cycle();
    check("bp_reload_valid", {31'd0, d1_valid}, 32'd1);
    check("bp_reload_data",  d1_data, 32'h11111111);
    d1_ready = 1'b0;

    // D1 stalled, D2 streams 8 words back-to-back.
    d2_ready = 1'b1;
    set_in(1'b1, 1'b1, 32'h00000100);
    #1;
    check("xch_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      in_data = 32'h00000100 + 32'(i);
      cycle();
      check("xch_d2_word", d2_data, 32'h00000100 + 32'(i));
      check("xch_d2_valid", {31'd0, d2_valid}, 32'd1);
    end
    check("xch_d1_held", d1_data, 32'h11111111);
    set_in(1'b0, 1'b0, '0);
    cycle();
    check("xch_d2_empty", {31'd0, d2_valid}, 32'd0);
    d2_ready = 1'b0;

    // Async reset pulse while D1 stalls holding A5A5A5A5.
    d1_ready = 1'b1;
    set_in(1'b1, 1'b0, 32'hA5A5A5A5);
    cycle();
    d1_ready = 1'b0;
    set_in(1'b0, 1'b0, '0);
    cycle();
    check("ar_d1_full", d1_data, 32'hA5A5A5A5);
    #2 reset_n = 1'b0;
    #1;
    check("ar_d1_valid_now", {31'd0, d1_valid}, 32'd0);
    check("ar_d1_data_now",  d1_data, 32'd0);
    model_reset();
    #1 reset_n = 1'b1;
    @(negedge clk);
    d1_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    check("ar_never_delivered", {31'd0, d1_valid}, 32'd0);

`ifdef DEMUX_CNT_EN
    // 17 drains on D1 wrap a 4-bit counter to 1.
    d1_ready = 1'b1;
    d2_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      set_in(1'b1, 1'b0, 32'h0000C000 + 32'(i));
      cycle();
    end
    set_in(1'b0, 1'b0, '0);
    d1_ready = 1'b0;
    cycle();
    check("cnt_d1_wrap", 32'(d1_count), 32'd1);
    check("cnt_d2_zero", 32'(d2_count), 32'd0);
`endif

    // Randomized traffic honouring the source-stability rule.
    hold = 1'b0;
    for (int i = 0; i < N_RAND; i++) begin
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = $urandom_range(0, 1) == 1;
        in_data  = $urandom;
      end
      d1_ready = ($urandom_range(0, 2) != 0);
      d2_ready = ($urandom_range(0, 3) == 0);
      cycle();
      hold = in_valid && !exp_ready;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
